seg_scan_decoder: RTL and testbench

// - Receive-side counterpart of the hex-to-7-segment encoder: watches a time-multiplexed

---
 rtl/seg_scan_decoder_pkg.sv | 26 ++
 rtl/seg_scan_decoder_if.sv | 23 ++
 rtl/seg7_pattern_decode.sv | 35 +++
 rtl/seg_scan_decoder.sv | 196 +++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the 7-segment scan decoder: segment patterns (abcdefg, a = bit 6),
// nibble codes for blank/undecodable slots, and the frame-assembly FSM encoding.
package seg_scan_decoder_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] NIB_BLANK = 4'hF;
    localparam logic [3:0] NIB_BAD   = 4'hE;

    typedef enum logic [1:0] {
        ST_ALIGN    = 2'd0,
        ST_ASSEMBLE = 2'd1,
        ST_PUBLISH  = 2'd2
    } state_e;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Display-bus and result signals of the scan decoder; the display side (or bench) is the
// master, the decoder is the slave.
interface seg_scan_decoder_if #(
    parameter int DIGITS = 4
);
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   blank_mask;
    logic                frame_valid;
    logic                pattern_err;
    logic                strobe_err;

    modport master (
        output an, seg,
        input  value, blank_mask, frame_valid, pattern_err, strobe_err
    );

    modport slave (
        input  an, seg,
        output value, blank_mask, frame_valid, pattern_err, strobe_err
    );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-7-segment encoder for digits 0..9 plus blank;
// anything else is flagged as undecodable.
module seg7_pattern_decode
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       bad
);

    always_comb begin
        nibble = NIB_BAD;
        blank  = 1'b0;
        bad    = 1'b0;
        case (seg)
            SEG_0:     nibble = 4'd0;
            SEG_1:     nibble = 4'd1;
            SEG_2:     nibble = 4'd2;
            SEG_3:     nibble = 4'd3;
            SEG_4:     nibble = 4'd4;
            SEG_5:     nibble = 4'd5;
            SEG_6:     nibble = 4'd6;
            SEG_7:     nibble = 4'd7;
            SEG_8:     nibble = 4'd8;
            SEG_9:     nibble = 4'd9;
            SEG_BLANK: begin
                nibble = NIB_BLANK;
                blank  = 1'b1;
            end
            default:   bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers BCD digits from a time-multiplexed 7-segment bus: synchronise, qualify each
// stable slot, decode, assemble a full frame and publish it with a one-cycle valid pulse.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_scan_decoder_if.slave bus
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_CAP  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [DIGITS-1:0] ALL_SEEN = '1;

    function automatic logic is_one_hot(input logic [DIGITS-1:0] v);
        return (v != '0) && ((v & (v - DIGITS'(1))) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] hot_index(input logic [DIGITS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[k]) idx = IDX_W'(k);
        end
        return idx;
    endfunction

    logic [DIGITS-1:0]   an_m_q, an_m_d, an_s_q, an_s_d, an_p_q, an_p_d;
    logic [6:0]          seg_m_q, seg_m_d, seg_s_q, seg_s_d, seg_p_q, seg_p_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    state_e              state_q, state_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic [4*DIGITS-1:0] shadow_nib_q, shadow_nib_d;
    logic [DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
    logic                pend_vld_q, pend_vld_d;
    logic [IDX_W-1:0]    pend_idx_q, pend_idx_d;
    logic [3:0]          pend_nib_q, pend_nib_d;
    logic                pend_blank_q, pend_blank_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   blank_mask_q, blank_mask_d;
    logic                frame_valid_q, frame_valid_d;
    logic                pattern_err_q, pattern_err_d;
    logic                strobe_err_q, strobe_err_d;

    logic             sample_same, capture, an_one_hot, cap_slot, cap_multi;
    logic [IDX_W-1:0] cur_idx;
    logic [3:0]       dec_nib;
    logic             dec_blank, dec_bad;
    logic             slot_vld;
    logic [IDX_W-1:0] slot_idx;
    logic [3:0]       slot_nib;
    logic             slot_blank;

    seg7_pattern_decode u_decode (
        .seg    (seg_s_q),
        .nibble (dec_nib),
        .blank  (dec_blank),
        .bad    (dec_bad)
    );

    // A capture fires once, on the cycle the stability count reaches its ceiling.
    assign sample_same = ({an_s_q, seg_s_q} == {an_p_q, seg_p_q});
    assign capture     = sample_same && (cnt_q == CNT_CAP);
    assign an_one_hot  = is_one_hot(an_s_q);
    assign cur_idx     = hot_index(an_s_q);
    assign cap_slot    = capture && an_one_hot;
    assign cap_multi   = capture && (an_s_q != '0) && !an_one_hot;

    always_comb begin
        an_m_d  = bus.an;
        an_s_d  = an_m_q;
        seg_m_d = bus.seg;
        seg_s_d = seg_m_q;
        an_p_d  = an_s_q;
        seg_p_d = seg_s_q;
        if (!sample_same)         cnt_d = '0;
        else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
        else                      cnt_d = cnt_q + CNT_W'(1);
    end

    // A slot captured while publishing is parked one cycle and replayed in ASSEMBLE.
    always_comb begin
        pend_vld_d   = (state_q == ST_PUBLISH) && cap_slot;
        pend_idx_d   = cur_idx;
        pend_nib_d   = dec_nib;
        pend_blank_d = dec_blank;
        slot_vld     = (state_q != ST_PUBLISH) && !cap_multi && (pend_vld_q || cap_slot);
        slot_idx     = pend_vld_q ? pend_idx_q   : cur_idx;
        slot_nib     = pend_vld_q ? pend_nib_q   : dec_nib;
        slot_blank   = pend_vld_q ? pend_blank_q : dec_blank;
    end

    always_comb begin
        seen_d         = seen_q;
        shadow_nib_d   = shadow_nib_q;
        shadow_blank_d = shadow_blank_q;
        if (slot_vld && (state_q == ST_ASSEMBLE || slot_idx == '0)) begin
            shadow_nib_d[4*slot_idx +: 4] = slot_nib;
            shadow_blank_d[slot_idx]      = slot_blank;
            // A repeated digit means we joined mid-scan: restart the frame from it.
            if (state_q == ST_ALIGN || seen_q[slot_idx])
                seen_d = DIGITS'(1) << slot_idx;
            else
                seen_d = seen_q | (DIGITS'(1) << slot_idx);
        end
        if (state_q == ST_PUBLISH || cap_multi) seen_d = '0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ALIGN: begin
                if (slot_vld && slot_idx == '0)
                    state_d = (seen_d == ALL_SEEN) ? ST_PUBLISH : ST_ASSEMBLE;
            end
            ST_ASSEMBLE: begin
                if (cap_multi)
                    state_d = ST_ALIGN;
                else if (slot_vld && seen_d == ALL_SEEN)
                    state_d = ST_PUBLISH;
            end
            ST_PUBLISH: state_d = cap_multi ? ST_ALIGN : ST_ASSEMBLE;
            default:    state_d = ST_ALIGN;
        endcase
    end

    always_comb begin
        value_d       = value_q;
        blank_mask_d  = blank_mask_q;
        frame_valid_d = 1'b0;
        if (state_q == ST_PUBLISH) begin
            value_d       = shadow_nib_q;
            blank_mask_d  = shadow_blank_q;
            frame_valid_d = 1'b1;
        end
        pattern_err_d = cap_slot && dec_bad;
        strobe_err_d  = cap_multi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_m_q        <= '0;
            an_s_q        <= '0;
            an_p_q        <= '0;
            seg_m_q       <= '0;
            seg_s_q       <= '0;
            seg_p_q       <= '0;
            cnt_q         <= '0;
            state_q       <= ST_ALIGN;
            seen_q        <= '0;
            pend_vld_q    <= 1'b0;
            value_q       <= '0;
            blank_mask_q  <= '0;
            frame_valid_q <= 1'b0;
            pattern_err_q <= 1'b0;
            strobe_err_q  <= 1'b0;
        end else begin
            an_m_q        <= an_m_d;
            an_s_q        <= an_s_d;
            an_p_q        <= an_p_d;
            seg_m_q       <= seg_m_d;
            seg_s_q       <= seg_s_d;
            seg_p_q       <= seg_p_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            seen_q        <= seen_d;
            pend_vld_q    <= pend_vld_d;
            value_q       <= value_d;
            blank_mask_q  <= blank_mask_d;
            frame_valid_q <= frame_valid_d;
            pattern_err_q <= pattern_err_d;
            strobe_err_q  <= strobe_err_d;
        end
    end

    // Shadow and parked-slot data are only read once seen/pend_vld mark them written.
    always_ff @(posedge clk) begin
        shadow_nib_q   <= shadow_nib_d;
        shadow_blank_q <= shadow_blank_d;
        pend_idx_q     <= pend_idx_d;
        pend_nib_q     <= pend_nib_d;
        pend_blank_q   <= pend_blank_d;
    end

    assign bus.value       = value_q;
    assign bus.blank_mask  = blank_mask_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.pattern_err = pattern_err_q;
    assign bus.strobe_err  = strobe_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: scans frames onto the display bus, queues expected frames
// as they are driven and compares them when frame_valid pulses.
module tb_seg_scan_decoder;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;
    localparam int SLOT   = 8;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  blank;
    } frame_t;

    typedef struct {
        logic [6:0] pat;
        logic [3:0] nib;
        logic [3:0] blank;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    frame_t exp_q[$];
    vec_t   tbl[12];
    int checks = 0, failures = 0;
    int fv_count = 0, perr_count = 0, serr_count = 0;
    int cyc = 0, last_fv_cyc = 0, last_slot_cyc = 0;
    int f0, p0, s0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        frame_t e;
        if (bus.frame_valid === 1'b1) begin
            fv_count++;
            last_fv_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame actual=%h/%b required=no frame",
                         bus.value, bus.blank_mask);
            end else begin
                e = exp_q.pop_front();
                chk("frame_value", 32'(bus.value), 32'(e.value));
                chk("frame_blank", 32'(bus.blank_mask), 32'(e.blank));
            end
        end
        if (bus.pattern_err === 1'b1) perr_count++;
        if (bus.strobe_err === 1'b1) serr_count++;
    end

    task automatic slot(input int k, input logic [6:0] p, input int n);
        bus.an  = DIGITS'(1) << k;
        bus.seg = p;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dead(input int n);
        bus.an  = '0;
        bus.seg = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan4(input logic [6:0] p0_i, input logic [6:0] p1_i,
                         input logic [6:0] p2_i, input logic [6:0] p3_i);
        slot(0, p0_i, SLOT);
        slot(1, p1_i, SLOT);
        slot(2, p2_i, SLOT);
        last_slot_cyc = cyc;
        slot(3, p3_i, SLOT);
    endtask

    task automatic expect_frame(input logic [15:0] v, input logic [3:0] b);
        frame_t f;
        f.value = v;
        f.blank = b;
        exp_q.push_back(f);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{7'h7E, 4'h0, 4'b0000};
        tbl[1]  = '{7'h30, 4'h1, 4'b0000};
        tbl[2]  = '{7'h6D, 4'h2, 4'b0000};
        tbl[3]  = '{7'h79, 4'h3, 4'b0000};
        tbl[4]  = '{7'h33, 4'h4, 4'b0000};
        tbl[5]  = '{7'h5B, 4'h5, 4'b0000};
        tbl[6]  = '{7'h5F, 4'h6, 4'b0000};
        tbl[7]  = '{7'h70, 4'h7, 4'b0000};
        tbl[8]  = '{7'h7F, 4'h8, 4'b0000};
        tbl[9]  = '{7'h7B, 4'h9, 4'b0000};
        tbl[10] = '{7'h00, 4'hF, 4'b0100};
        tbl[11] = '{7'h7C, 4'hE, 4'b0000};

        bus.an  = '0;
        bus.seg = '0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_value", 32'(bus.value), 32'h0);
        chk("reset_blank", 32'(bus.blank_mask), 32'h0);
        chk("reset_frame_valid", 32'(bus.frame_valid), 32'h0);
        chk("reset_pattern_err", 32'(bus.pattern_err), 32'h0);
        chk("reset_strobe_err", 32'(bus.strobe_err), 32'h0);
        rst_n = 1'b1;
        dead(10);

        // Basic scan: 3,1,8,0 on digits 0..3
        expect_frame(16'h0813, 4'b0000);
        expect_frame(16'h0813, 4'b0000);
        scan4(7'h79, 7'h30, 7'h7F, 7'h7E);
        scan4(7'h79, 7'h30, 7'h7F, 7'h7E);
        dead(12);
        chk("basic_frames", fv_count, 2);
        chk("latency", last_fv_cyc - last_slot_cyc, 2 + STABLE + 2);

        // Every pattern on digit 2
        f0 = fv_count;
        p0 = perr_count;
        for (int i = 0; i < 12; i++) begin
            expect_frame({4'h0, tbl[i].nib, 4'h1, 4'h3}, tbl[i].blank);
            scan4(7'h79, 7'h30, tbl[i].pat, 7'h7E);
        end
        dead(12);
        chk("table_frames", fv_count - f0, 12);
        chk("table_pattern_err", perr_count - p0, 1);

        // Digit 3 held one cycle short of qualifying
        f0 = fv_count;
        slot(0, 7'h79, SLOT);
        slot(1, 7'h30, SLOT);
        slot(2, 7'h7F, SLOT);
        slot(3, 7'h7F, STABLE - 1);
        dead(12);
        chk("glitch_no_frame", fv_count - f0, 0);
        expect_frame(16'h0813, 4'b0000);
        scan4(7'h79, 7'h30, 7'h7F, 7'h7E);
        dead(12);
        chk("glitch_recover_frames", fv_count - f0, 1);

        // Multi-hot strobe mid-frame forces realignment on digit 0
        f0 = fv_count;
        s0 = serr_count;
        slot(0, 7'h79, SLOT);
        slot(1, 7'h30, SLOT);
        bus.an  = 4'b0011;
        bus.seg = 7'h7E;
        repeat (8) @(posedge clk);
        #1;
        slot(1, 7'h5B, SLOT);
        slot(2, 7'h5B, SLOT);
        slot(3, 7'h5B, SLOT);
        dead(12);
        chk("strobe_err_pulse", serr_count - s0, 1);
        chk("strobe_no_frame", fv_count - f0, 0);
        expect_frame(16'h0813, 4'b0000);
        scan4(7'h79, 7'h30, 7'h7F, 7'h7E);
        dead(12);
        chk("strobe_recover_frames", fv_count - f0, 1);

        // Order 0,1,1,2,3,0: repeat restarts the frame at the second digit 1
        f0 = fv_count;
        expect_frame(16'h6479, 4'b0000);
        slot(0, 7'h5B, SLOT);
        slot(1, 7'h6D, SLOT);
        slot(1, 7'h70, SLOT);
        slot(2, 7'h33, SLOT);
        slot(3, 7'h5F, SLOT);
        slot(0, 7'h7B, SLOT);
        dead(12);
        chk("repeat_frames", fv_count - f0, 1);

        // Asynchronous reset in the middle of a frame
        f0 = fv_count;
        slot(0, 7'h79, SLOT);
        slot(1, 7'h30, 4);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_value", 32'(bus.value), 32'h0);
        chk("async_reset_blank", 32'(bus.blank_mask), 32'h0);
        chk("async_reset_frame_valid", 32'(bus.frame_valid), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        slot(2, 7'h7F, SLOT);
        slot(3, 7'h7E, SLOT);
        dead(12);
        chk("reset_no_partial", fv_count - f0, 0);
        expect_frame(16'h0813, 4'b0000);
        scan4(7'h79, 7'h30, 7'h7F, 7'h7E);
        dead(12);
        chk("reset_recover_frames", fv_count - f0, 1);

        chk("queue_drained", exp_q.size(), 0);
        chk("strobe_err_total", serr_count, 1);
        chk("pattern_err_total", perr_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
